fetch_unit: RTL



---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 82 ++++++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipelined core.
//   word_t         32-bit machine word / address
//   fetch_state_t  fetch FSM states (FETCH, DROP, HALTED)
//   fetch_entry_t  one fetch-queue entry {instr, pc_4}
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DROP   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc_4;
  } fetch_entry_t;

  localparam word_t WORD_BYTES = 32'd4;

  // Sequential PC step. Wraps modulo 2^32.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + WORD_BYTES;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetched {instr, pc_4} entries.
// Ports:
//   CLK, nRST  clock / async active-low reset
//   enq        push wdata (ignored when full or flushing)
//   deq        pop head (ignored when empty or flushing)
//   flush      drop all entries this cycle
//   wdata      entry to push
//   count      occupancy 0..QDEPTH
//   head       oldest entry (raw storage; undefined while empty)
//   full       count == QDEPTH
//   empty      count == 0
module fetch_queue
  import cpu_types_pkg::*;
#(
  parameter int QDEPTH = 2,
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW = $clog2(QDEPTH + 1)
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          enq,
  input  logic          deq,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output logic [CW-1:0] count,
  output fetch_entry_t  head,
  output logic          full,
  output logic          empty
);

  fetch_entry_t   mem_q [QDEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_enq, do_deq;

  assign full   = (count_q == CW'(QDEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign head   = mem_q[rd_ptr_q];

  assign do_enq = enq & ~full  & ~flush;
  assign do_deq = deq & ~empty & ~flush;

  // QDEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_enq) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_deq) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge CLK) begin
    if (do_enq) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the IF/ID register.
// Owns the PC, issues icache reads, buffers returned words with PC+4,
// and handles redirects (incl. draining an in-flight miss) and halt.
// Ports:
//   CLK, nRST       clock / async active-low reset
//   iREN, iaddr     icache read request and word address
//   ihit, iload     icache response strobe and data
//   stall           IF/ID holding; head is not consumed
//   redirect,
//   redirect_addr   taken branch/jump target (flushes the queue)
//   halt            stop fetching until reset
//   valid_out       queue head valid
//   instr_out       head instruction (0 when empty)
//   pc_4_out        head PC+4 (0 when empty)
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT = 32'h0000_0000,
  parameter int    QDEPTH  = 2
) (
  input  logic  CLK,
  input  logic  nRST,
  output logic  iREN,
  output word_t iaddr,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  halt,
  output logic  valid_out,
  output word_t instr_out,
  output word_t pc_4_out
);

  localparam int CW = $clog2(QDEPTH + 1);

  fetch_state_t   state_q, state_d;
  word_t          pc_q, pc_d;
  word_t          saved_q, saved_d;

  logic           q_enq, q_deq, q_flush;
  logic           q_full, q_empty;
  logic [CW-1:0]  q_count;
  fetch_entry_t   q_head, q_wdata;
  word_t          drop_target;

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .CLK   (CLK),
    .nRST  (nRST),
    .enq   (q_enq),
    .deq   (q_deq),
    .flush (q_flush),
    .wdata (q_wdata),
    .count (q_count),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // In DROP the request must stay up until the abandoned miss returns,
  // regardless of queue occupancy (the queue is empty there anyway).
  always_comb begin
    iREN = 1'b0;
    case (state_q)
      FETCH:   iREN = ~q_full;
      DROP:    iREN = 1'b1;
      default: iREN = 1'b0;
    endcase
  end

  assign iaddr     = pc_q;
  assign valid_out = (q_count != '0);
  assign instr_out = q_empty ? '0 : q_head.instr;
  assign pc_4_out  = q_empty ? '0 : q_head.pc_4;

  assign q_wdata = '{instr: iload, pc_4: pc_plus4(pc_q)};
  assign q_enq   = (state_q == FETCH) & iREN & ihit & ~redirect & ~halt;
  // Halt flushes from any state; redirect is ignored once halted.
  assign q_flush = halt | (redirect & (state_q != HALTED));
  assign q_deq   = valid_out & ~stall & ~q_flush;

  // A redirect arriving while draining replaces the pending target.
  assign drop_target = redirect ? redirect_addr : saved_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    saved_d = saved_q;
    if (halt) begin
      state_d = HALTED;
    end else begin
      case (state_q)
        FETCH: begin
          if (redirect) begin
            if (iREN && !ihit) begin
              saved_d = redirect_addr;
              state_d = DROP;
            end else begin
              pc_d = redirect_addr;
            end
          end else if (q_enq) begin
            pc_d = pc_plus4(pc_q);
          end
        end
        DROP: begin
          if (ihit) begin
            pc_d    = drop_target;
            state_d = FETCH;
          end else begin
            saved_d = drop_target;
          end
        end
        default: state_d = HALTED;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      saved_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      saved_q <= saved_d;
    end
  end

endmodule
